// File: rtl/branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// branch_resolve_unit
//
// Carries each fetched instruction's direction prediction down a DEPTH-entry
// shift register until it reaches the execute slot (entry DEPTH-1). When the
// execute slot holds a conditional branch or jump, the prediction is compared
// with the resolved outcome and a one-cycle branch history table update is
// issued. On a wrong prediction a one-cycle mispredict pulse with the correct
// next PC is issued and every younger tracked entry is killed.
//
// Ports
//   clk, arst_n          clock, asynchronous active-low reset
//   en                   pipeline advance (0 = stall, hold state, no pulses)
//   flush                external kill, clears all tracked entries
//   if_valid/pc/prediction  fetch-side entry loaded on each advance
//   ex_is_branch/taken/jump/target  execute-side resolution inputs
//   bht_en/write_addr/was_taken/jumped  registered BHT update (one-cycle strobe)
//   mispredict, redirect_pc  registered redirect pulse and correct next PC
//   branch_count, mispredict_count  saturating statistics counters
// -----------------------------------------------------------------------------
module branch_resolve_unit #(
    parameter int PC_W  = 64,
    parameter int LOWER = 5,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             en,
    input  logic             flush,
    input  logic             if_valid,
    input  logic [PC_W-1:0]  if_pc,
    input  logic             if_prediction,
    input  logic             ex_is_branch,
    input  logic             ex_taken,
    input  logic             ex_jump,
    input  logic [PC_W-1:0]  ex_target,
    output logic             bht_en,
    output logic [LOWER-1:0] bht_write_addr,
    output logic             bht_was_taken,
    output logic             bht_jumped,
    output logic             mispredict,
    output logic [PC_W-1:0]  redirect_pc,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_count
);

    localparam int EX = DEPTH - 1;

    // Tracked entries: valid bits are reset, payload is not.
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [PC_W-1:0]  pc_q [DEPTH];
    logic [DEPTH-1:0] pred_q;

    logic             resolve;
    logic             actual;
    logic             mis;
    logic [PC_W-1:0]  ex_pc;
    logic [PC_W-1:0]  redirect_d;

    logic             bht_en_q;
    logic [LOWER-1:0] bht_addr_q;
    logic             bht_taken_q;
    logic             bht_jump_q;
    logic             mis_q;
    logic [PC_W-1:0]  redirect_q;
    logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0] mis_cnt_q, mis_cnt_d;

    assign ex_pc      = pc_q[EX];
    assign actual     = ex_taken | ex_jump;
    // flush wins over resolution; a stalled slot is re-evaluated when en returns.
    assign resolve    = en & ~flush & valid_q[EX] & (ex_is_branch | ex_jump);
    assign mis        = resolve & (actual != pred_q[EX]);
    assign redirect_d = actual ? ex_target : ex_pc + PC_W'(4);

    // NOTE: every variable written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        valid_d = valid_q;
        if (flush || mis) begin
            // On a mispredict the resolved entry shifts out and everything
            // that would shift in behind it is wrong-path, so all go invalid.
            valid_d = '0;
        end else if (en) begin
            valid_d[0] = if_valid;
            for (int k = 1; k < DEPTH; k++) begin
                valid_d[k] = valid_q[k-1];
            end
        end
    end

    always_comb begin
        branch_cnt_d = branch_cnt_q;
        mis_cnt_d    = mis_cnt_q;
        if (resolve && !(&branch_cnt_q)) begin
            branch_cnt_d = branch_cnt_q + CNT_W'(1);
        end
        if (mis && !(&mis_cnt_q)) begin
            mis_cnt_d = mis_cnt_q + CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            valid_q      <= '0;
            bht_en_q     <= 1'b0;
            bht_addr_q   <= '0;
            bht_taken_q  <= 1'b0;
            bht_jump_q   <= 1'b0;
            mis_q        <= 1'b0;
            redirect_q   <= '0;
            branch_cnt_q <= '0;
            mis_cnt_q    <= '0;
        end else begin
            valid_q      <= valid_d;
            bht_en_q     <= resolve;
            bht_addr_q   <= resolve ? ex_pc[LOWER+1:2] : '0;
            bht_taken_q  <= resolve & ex_taken;
            bht_jump_q   <= resolve & ex_jump;
            mis_q        <= mis;
            redirect_q   <= resolve ? redirect_d : '0;
            branch_cnt_q <= branch_cnt_d;
            mis_cnt_q    <= mis_cnt_d;
        end
    end

    // NOTE: the PC/prediction payload is not reset; it is only ever observed
    // behind a valid bit, which is reset.
    always_ff @(posedge clk) begin
        if (en) begin
            pc_q[0]   <= if_pc;
            pred_q[0] <= if_prediction;
            for (int k = 1; k < DEPTH; k++) begin
                pc_q[k]   <= pc_q[k-1];
                pred_q[k] <= pred_q[k-1];
            end
        end
    end

    assign bht_en           = bht_en_q;
    assign bht_write_addr   = bht_addr_q;
    assign bht_was_taken    = bht_taken_q;
    assign bht_jumped       = bht_jump_q;
    assign mispredict       = mis_q;
    assign redirect_pc      = redirect_q;
    assign branch_count     = branch_cnt_q;
    assign mispredict_count = mis_cnt_q;

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Tracks each fetched instruction's direction prediction through the pipeline until execute.
- At execute, compares the prediction with the resolved outcome and produces the update for the branch history table: write address, was_taken and jumped.
- On a wrong prediction, produces a one-cycle mispredict pulse with the redirect PC and kills the wrong-path entries it holds.
- Sits between fetch (which supplies PC and prediction) and the branch history table write port. It also feeds the fetch PC mux.

Parameters:
- PC_W, 64, width of program counter.
- LOWER, 5, number of PC index bits sent to the branch history table.
- DEPTH, 2, number of pipeline advances from fetch to the execute slot (min 1, max 4).
- CNT_W, 16, width of the saturating statistics counters.

Ports:
- clk  in  1  clock
- arst_n  in  1  asynchronous active-low reset
- en  in  1  pipeline advance. 0 = stall: hold all tracked state and suppress update pulses.
- flush  in  1  external kill (exception/trap). Clears all tracked entries.
- if_valid  in  1  a fetched instruction enters this cycle
- if_pc  in  PC_W  PC of the fetched instruction
- if_prediction  in  1  branch history table prediction for if_pc (1 = taken)
- ex_is_branch  in  1  execute-slot instruction is a conditional branch
- ex_taken  in  1  resolved branch condition
- ex_jump  in  1  execute-slot instruction is an unconditional jump
- ex_target  in  PC_W  resolved target address
- bht_en  out  1  branch history table update strobe
- bht_write_addr  out  LOWER  equals tracked pc[LOWER+1:2]
- bht_was_taken  out  1  resolved condition
- bht_jumped  out  1  instruction was a jump
- mispredict  out  1  one-cycle redirect pulse
- redirect_pc  out  PC_W  correct next PC. Valid when mispredict=1.
- branch_count  out  CNT_W  resolved branches and jumps, saturating
- mispredict_count  out  CNT_W  mispredictions, saturating

Behaviour:
- Reset: async and active-low. All tracked entries become invalid. Every output resets to 0, including both counters.
- Tracking: a shift register of DEPTH entries, each holding {valid, pc, pred}.
  - When en=1, entry 0 loads {if_valid, if_pc, if_prediction} and entry k loads entry k-1.
  - The execute slot is entry DEPTH-1.
  - When en=0, every entry holds.
- Resolution happens only in a cycle with en=1, flush=0, execute-slot valid=1, and ex_is_branch or ex_jump set.
  - actual = ex_taken | ex_jump
  - mis = (actual != pred)
- All outputs are registered and asserted on the clock edge ending the resolution cycle. Each pulse lasts exactly one cycle.
  - bht_en = 1
  - bht_write_addr = pc[LOWER+1:2]
  - bht_was_taken = ex_taken
  - bht_jumped = ex_jump
  - mispredict = mis
- redirect_pc = ex_target when actual=1, otherwise pc + 4, modulo 2^PC_W.
- A valid execute-slot instruction that is neither a branch nor a jump produces no pulse.
- On a mispredict, all entries younger than the execute slot are invalidated, including the entry being loaded from fetch in the same cycle. The resolved entry itself shifts out normally.
- Counters, on a resolution:
  - branch_count increments by 1.
  - mispredict_count increments by 1 when mis=1.
  - Both saturate at all-ones and never wrap.
- flush=1 with en=0 or en=1: all entries are invalidated on that edge. No resolution is reported, even if the execute slot held a branch, and the counters are unchanged. flush takes priority over resolution.
- Stall: with en=0, the update and mispredict outputs are 0 in the following cycle. The execute slot is re-evaluated once en returns to 1, so exactly one pulse is produced per tracked branch.
- Reset asserted mid-operation drops all in-flight entries immediately. No pulse is produced after reset deasserts until new entries reach the execute slot.
- ex_* inputs are ignored whenever the execute slot is invalid.

Test Plan:
- Reset, then en=1 idle for 5 cycles -> every output stays 0; branch_count=0.
- if_pc=0x40, pred=0, fetched at cycle 0. At cycle 2, ex_is_branch=1, ex_taken=1, ex_target=0x80.
  - Cycle 3: bht_en=1, bht_write_addr=0x10, mispredict=1, redirect_pc=0x80.
  - The entry fetched at cycle 1 and the entry being fetched at cycle 2 are killed; no pulse is produced for either.
  - mispredict_count=1.
- if_pc=0x44, pred=1. At execute, ex_is_branch=1, ex_taken=0.
  - mispredict=1, redirect_pc=0x48, bht_was_taken=0.
- ex_jump=1 with pred=1 -> bht_en=1, bht_jumped=1, mispredict=0.
  - branch_count increments by 1; mispredict_count does not change.
- A branch sits in the execute slot with en=0 for 3 cycles, then en=1.
  - No pulse during the stall.
  - Exactly one bht_en pulse after en rises.
- flush=1 while a branch is in the execute slot -> no bht_en and no mispredict; all entries become invalid.
- Preload mispredict_count=0xFFFE, then force 3 mispredictions -> count goes to 0xFFFF and holds at 0xFFFF.
